// File: rtl/div_16x8_seq.sv
// div_16x8_seq: sequential 16-by-8 unsigned restoring divider, one quotient bit per cycle.
// Latency: 17 cycles from acceptance to out_valid for B!=0, 1 cycle for B==0 (divide-by-zero).
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   A, B            16-bit dividend, 8-bit divisor, qualified by in_valid / in_ready
//   Q, R, DZ        quotient, remainder, divide-by-zero flag, qualified by out_valid / out_ready
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        DZ,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] nreg;     // dividend shifting out at the top, quotient shifting in at the bottom
    logic [7:0]  dreg;     // captured divisor
    logic [7:0]  preg;     // partial remainder; always < divisor between steps, so bit 8 is never needed
    logic [4:0]  cnt;
    logic        dz_q;

    // One restoring step. The 9-bit shifted remainder is compared against the
    // zero-extended divisor; when it is >= divisor the difference is < 256, so
    // the subtraction can be done on the low 8 bits without losing anything.
    logic [8:0]  p_shift;
    logic        q_bit;
    logic [7:0]  p_next;

    always_comb begin
        p_shift = {preg, nreg[15]};
        q_bit   = (p_shift >= {1'b0, dreg});
        p_next  = q_bit ? (p_shift[7:0] - dreg) : p_shift[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            nreg      <= 16'd0;
            dreg      <= 8'd0;
            preg      <= 8'd0;
            cnt       <= 5'd0;
            dz_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dreg <= B;
                        cnt  <= 5'd0;
                        if (B == 8'd0) begin
                            // Divide-by-zero: present the saturated quotient and the
                            // low dividend byte directly, skipping the iteration.
                            nreg      <= 16'hFFFF;
                            preg      <= A[7:0];
                            dz_q      <= 1'b1;
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            nreg     <= A;
                            preg     <= 8'd0;
                            dz_q     <= 1'b0;
                            state    <= CALC;
                            in_ready <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    nreg <= {nreg[14:0], q_bit};
                    preg <= p_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Q  = nreg;
    assign R  = preg;
    assign DZ = dz_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
module tb_div_16x8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = 16'd0;
    logic [7:0]  B = 8'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        DZ;
    logic        out_valid;

    div_16x8_seq dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid), .in_ready(in_ready),
        .Q(Q), .R(R), .DZ(DZ), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks one outstanding operation: busy from acceptance until the result
    // transfers; the result appears after a fixed number of edges.
    bit          m_busy = 1'b0;
    int          m_cyc  = 0;
    int          m_a    = 0;
    int          m_b    = 0;

    function automatic bit m_ov();
        return m_busy && (m_cyc >= ((m_b == 0) ? 1 : 17));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cyc  = 0;
        end else if (m_busy) begin
            if (m_ov() && out_ready) m_busy = 1'b0;
            else m_cyc++;
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_cyc  = 1;
            m_a    = int'(A);
            m_b    = int'(B);
        end
    end

    // Compare process: every cycle out of reset, handshake outputs against the
    // model; whenever a result is presented, Q/R/DZ against plain arithmetic.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_ov()));
            if (m_ov() && out_valid) begin
                if (m_b == 0) begin
                    chk("Q_dz", 32'(Q), 32'hFFFF);
                    chk("R_dz", 32'(R), 32'(m_a % 256));
                    chk("DZ_dz", 32'(DZ), 32'd1);
                end else begin
                    chk("Q", 32'(Q), 32'(m_a / m_b));
                    chk("R", 32'(R), 32'(m_a % m_b));
                    chk("DZ", 32'(DZ), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus tasks (called and returning at a negedge) ----------------
    task automatic send(input logic [15:0] a, input logic [7:0] b);
        int guard;
        A = a; B = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'($urandom);       // must not disturb the operation in flight
        B = 8'($urandom);
    endtask

    // Waits for the result, checks latency, optionally stalls (and injects a
    // request during the stall), then checks literal or identity expectations.
    task automatic recv(input logic [15:0] a, input logic [7:0] b, input bit lit,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz,
                        input int stall, input bit inject);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
        if (inject) begin
            A = 16'd9; B = 8'd3; in_valid = 1'b1;
        end
        repeat (stall) @(negedge clk);
        if (lit) begin
            chk("Q_lit", 32'(Q), 32'(eq));
            chk("R_lit", 32'(R), 32'(er));
            chk("DZ_lit", 32'(DZ), 32'(edz));
        end else begin
            chk("identity", 32'(Q) * 32'(b) + 32'(R), 32'(a));
            chk("rem_lt_div", 32'(R < b), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        repeat (2) @(negedge clk);
        // reset values
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q", 32'(Q), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_DZ", 32'(DZ), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed, literal expectations
        send(16'd1000, 8'd7);    recv(16'd1000, 8'd7, 1, 16'd142, 8'd6, 1'b0, 0, 0);
        send(16'hFFFF, 8'd1);    recv(16'hFFFF, 8'd1, 1, 16'd65535, 8'd0, 1'b0, 0, 0);
        send(16'd50000, 8'd200); recv(16'd50000, 8'd200, 1, 16'd250, 8'd0, 1'b0, 0, 0);
        send(16'd5, 8'd255);     recv(16'd5, 8'd255, 1, 16'd0, 8'd5, 1'b0, 0, 0);
        send(16'h1234, 8'd0);    recv(16'h1234, 8'd0, 1, 16'hFFFF, 8'h34, 1'b1, 0, 0);

        // backpressure with an ignored request during the stall
        send(16'd1000, 8'd7);    recv(16'd1000, 8'd7, 1, 16'd142, 8'd6, 1'b0, 10, 1);
        send(16'd9, 8'd3);       recv(16'd9, 8'd3, 1, 16'd3, 8'd0, 1'b0, 0, 0);

        // reset during CALC cycle 8
        send(16'd1000, 8'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_Q", 32'(Q), 32'd0);
        chk("abort_R", 32'(R), 32'd0);
        chk("abort_DZ", 32'(DZ), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (25) @(negedge clk);
        chk("abort_no_stale", 32'(out_valid), 32'd0);
        send(16'd100, 8'd10);    recv(16'd100, 8'd10, 1, 16'd10, 8'd0, 1'b0, 0, 0);

        // random sweep, nonzero divisors, random short stalls
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            if (i < 4) ra = (i < 2) ? 16'hFFFF : 16'd0;
            send(ra, rb);
            recv(ra, rb, 0, 16'd0, 8'd0, 1'b0, int'($urandom_range(0, 2)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
